// File: rtl/lea_pkg.sv
// -----------------------------------------------------------------------------
// lea_pkg
// Shared constants and helpers for the LEA block cipher datapath.
//   LEA_DELTA0..LEA_DELTA7 : the eight 32-bit key-schedule constants
//   LEA_DELTA              : the same constants as an 8-entry packed array,
//                            entry j holding LEA_DELTAj
//   rol32(x, n)            : 32-bit rotate left by n (0..31)
// -----------------------------------------------------------------------------
package lea_pkg;

    localparam int LEA_WORD_W = 32;
    localparam int LEA_NUM_DELTA = 8;

    localparam logic [31:0] LEA_DELTA0 = 32'hC3EF_E9DB;
    localparam logic [31:0] LEA_DELTA1 = 32'h4462_6B02;
    localparam logic [31:0] LEA_DELTA2 = 32'h79E2_7C8A;
    localparam logic [31:0] LEA_DELTA3 = 32'h78DF_30EC;
    localparam logic [31:0] LEA_DELTA4 = 32'h715E_A49E;
    localparam logic [31:0] LEA_DELTA5 = 32'hC785_DA0A;
    localparam logic [31:0] LEA_DELTA6 = 32'hE04E_F22A;
    localparam logic [31:0] LEA_DELTA7 = 32'hE5C4_0957;

    // Packed so that LEA_DELTA[j] selects LEA_DELTAj directly.
    localparam logic [LEA_NUM_DELTA-1:0][31:0] LEA_DELTA = {
        LEA_DELTA7, LEA_DELTA6, LEA_DELTA5, LEA_DELTA4,
        LEA_DELTA3, LEA_DELTA2, LEA_DELTA1, LEA_DELTA0
    };

    // Rotate by shifting a doubled copy: the upper half of {x,x} << n is
    // exactly ROL_n(x), with no special case for n == 0.
    function automatic logic [31:0] rol32(input logic [31:0] x, input logic [4:0] n);
        logic [63:0] w_dbl;
        w_dbl = {x, x} << n;
        return w_dbl[63:32];
    endfunction

endpackage

// File: rtl/lea_rot_reg.sv
// -----------------------------------------------------------------------------
// lea_rot_reg
// One 32-bit free-running rotate register. Asynchronously loads INIT while
// rst_n is low; rotates left by one bit on every rising clk edge otherwise,
// so after k edges q == ROL_(k mod 32)(INIT).
//   clk   : in  system clock
//   rst_n : in  asynchronous active-low reset
//   q     : out register contents (driven straight from the flop)
// -----------------------------------------------------------------------------
module lea_rot_reg
    import lea_pkg::*;
#(
    parameter logic [31:0] INIT = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] q
);

    logic [31:0] r_q;

    // NOTE: state registers use non-blocking assignments so every rotate
    // register in the array samples its old value on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= INIT;
        end else begin
            r_q <= rol32(r_q, 5'd1);
        end
    end

    assign q = r_q;

endmodule

// File: rtl/lea_key_constant.sv
// -----------------------------------------------------------------------------
// lea_key_constant
// Supplies the eight LEA key-schedule constants, each already rotated for the
// current round, so the key-schedule datapath (one round per clock) reads
// ROL_i(delta) without a barrel shifter. Free-running from reset release; the
// pattern repeats every 32 edges.
//   clk    : in  system clock
//   rst_n  : in  asynchronous active-low reset (loads the unrotated deltas)
//   E0..E7 : out ROL_n(deltaj), n = clock edges since reset release (mod 32)
// -----------------------------------------------------------------------------
module lea_key_constant
    import lea_pkg::*;
#(
    // Fixed by the LEA standard; the rotate registers are 32 bits wide.
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [WIDTH-1:0] E0,
    output logic [WIDTH-1:0] E1,
    output logic [WIDTH-1:0] E2,
    output logic [WIDTH-1:0] E3,
    output logic [WIDTH-1:0] E4,
    output logic [WIDTH-1:0] E5,
    output logic [WIDTH-1:0] E6,
    output logic [WIDTH-1:0] E7
);

    logic [LEA_NUM_DELTA-1:0][WIDTH-1:0] w_e;

    for (genvar g = 0; g < LEA_NUM_DELTA; g++) begin : g_rot
        lea_rot_reg #(
            .INIT (LEA_DELTA[g])
        ) u_rot_reg (
            .clk   (clk),
            .rst_n (rst_n),
            .q     (w_e[g])
        );
    end

    // Pure wiring: each port is the flop output of its rotate register.
    assign E0 = w_e[0];
    assign E1 = w_e[1];
    assign E2 = w_e[2];
    assign E3 = w_e[3];
    assign E4 = w_e[4];
    assign E5 = w_e[5];
    assign E6 = w_e[6];
    assign E7 = w_e[7];

endmodule

// File: tb/tb_lea_key_constant.sv
// -----------------------------------------------------------------------------
// tb_lea_key_constant
// Directed bench for lea_key_constant. Expected values are hand-computed
// constants plus a bench-local rotate model seeded from those constants.
// Outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_lea_key_constant;

    logic        clk;
    logic        rst_n;
    logic [31:0] E0, E1, E2, E3, E4, E5, E6, E7;

    int n_tests = 0;
    int n_fail  = 0;

    // Reset values, typed in by hand.
    logic [31:0] delta [8] = '{
        32'hC3EFE9DB, 32'h44626B02, 32'h79E27C8A, 32'h78DF30EC,
        32'h715EA49E, 32'hC785DA0A, 32'hE04EF22A, 32'hE5C40957
    };
    // ROL1 of each delta, hand-computed.
    logic [31:0] delta_rol1 [8] = '{
        32'h87DFD3B7, 32'h88C4D604, 32'hF3C4F914, 32'hF1BE61D8,
        32'hE2BD493C, 32'h8F0BB415, 32'hC09DE455, 32'hCB8812AF
    };

    lea_key_constant u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .E0    (E0),
        .E1    (E1),
        .E2    (E2),
        .E3    (E3),
        .E4    (E4),
        .E5    (E5),
        .E6    (E6),
        .E7    (E7)
    );

    initial clk = 1'b0;
    always #100 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Bench-local rotate written as shift-or, independent of the design.
    function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
        int m;
        m = n % 32;
        if (m == 0) return x;
        return (x << m) | (x >> (32 - m));
    endfunction

    function automatic logic [31:0] dut_out(input int j);
        case (j)
            0: return E0;
            1: return E1;
            2: return E2;
            3: return E3;
            4: return E4;
            5: return E5;
            6: return E6;
            default: return E7;
        endcase
    endfunction

    task automatic check_all(input string tag, input int k);
        for (int j = 0; j < 8; j++)
            check($sformatf("%s E%0d k=%0d", tag, j, k), dut_out(j), rotl(delta[j], k));
    endtask

    task automatic check_rol1_table(input string tag);
        for (int j = 0; j < 8; j++)
            check($sformatf("%s E%0d", tag, j), dut_out(j), delta_rol1[j]);
    endtask

    task automatic edge_and_sample();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int k;
        rst_n = 1'b0;

        // Reset held low with the clock running: deltas, never changing.
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check_all("rst_hold", 0);
        end

        // Release away from the rising edge, then count edges.
        rst_n = 1'b1;
        k = 0;
        edge_and_sample();
        k++;
        check_rol1_table("edge1");

        while (k < 4) begin
            edge_and_sample();
            k++;
            check_all("run", k);
        end
        check("edge4 E0 hand", E0, 32'h3EFE9DBC);

        while (k < 32) begin
            edge_and_sample();
            k++;
            check_all("run", k);
        end
        check_all("wrap32", 0);
        edge_and_sample();
        k++;
        check_rol1_table("wrap33");

        // Mid-cycle asynchronous reset after 7 edges of a fresh run.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 7; c++) edge_and_sample();
        check_all("pre_mid_rst", 7);
        @(posedge clk);
        #50;
        rst_n = 1'b0;
        #1;
        check_all("mid_rst_async", 0);
        @(negedge clk);
        check_all("mid_rst_hold", 0);
        rst_n = 1'b1;
        edge_and_sample();
        check_rol1_table("mid_rst_edge1");

        // Long free run: no X/Z, period-32 pattern throughout.
        k = 1;
        for (int c = 0; c < 100; c++) begin
            edge_and_sample();
            k++;
            check("no_xz", {31'd0, $isunknown({E0, E1, E2, E3, E4, E5, E6, E7})}, 32'd0);
            check_all("long", k);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
